// File: rtl/line_drain.sv
// line_drain: read-side companion of the camera line FIFO.
// Waits for the FIFO's line-level almost-full flag. It then reads exactly one line of
// bytes and forwards them on a valid/ready byte stream. The stream carries start/end-of-line
// markers and a line index.
//
// Ports:
//   clk        read clock (FIFO rd_clk)
//   rstn       synchronous active-low reset
//   line_rdy   FIFO almost-full flag, asynchronous to clk (synchronised here)
//   frame_rst  one-cycle pulse: next line started reports index 0
//   fifo_ren   FIFO read enable
//   fifo_rdata FIFO read data, valid one cycle after fifo_ren
//   m_data     output byte
//   m_valid    output byte valid
//   m_ready    downstream accept
//   m_sol      first byte of a line (qualified by m_valid)
//   m_eol      last byte of a line (qualified by m_valid)
//   m_line     index of the current line, stable for the whole line
//   busy       high from line start until the last byte is accepted
module line_drain #(
   parameter int unsigned LINE_BYTES = 2560,
   parameter int unsigned LINES      = 720,
   parameter int unsigned LINE_W     = 11,
   parameter int unsigned GAP_CYC    = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              line_rdy,
   input  logic              frame_rst,
   output logic              fifo_ren,
   input  logic [7:0]        fifo_rdata,
   output logic [7:0]        m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_sol,
   output logic              m_eol,
   output logic [LINE_W-1:0] m_line,
   output logic              busy
);

   localparam int unsigned CNT_W = $clog2(LINE_BYTES + 1);
   localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);

   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(LINE_BYTES);
   localparam logic [CNT_W-1:0]  ONE_CNT   = CNT_W'(1);
   localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);

   typedef enum logic [1:0] {StIdle, StRead, StFlush, StGap} state_e;

   state_e            state_q, state_d;
   logic              rdy_m_q, rdy_s_q;
   logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
   logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic [1:0]        occ_q, occ_d;
   logic [7:0]        buf0_q, buf0_d;
   logic [7:0]        buf1_q, buf1_d;
   logic              inflight_q;
   logic              pend_q, pend_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic              busy_q, busy_d;

   logic              pop;
   logic              last_pop;
   logic [2:0]        fill;

   // Output side and read throttle.
   always_comb begin
      m_valid  = (occ_q != 2'd0);
      m_data   = buf0_q;
      m_sol    = m_valid && (out_cnt_q == FULL_CNT);
      m_eol    = m_valid && (out_cnt_q == ONE_CNT);
      m_line   = line_q;
      busy     = busy_q;
      pop      = m_valid && m_ready;
      last_pop = pop && (out_cnt_q == ONE_CNT);
      // Slots committed after this edge: buffered plus in flight minus the byte leaving now.
      fill     = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
      fifo_ren = (state_q == StRead) && (rd_cnt_q != '0) && (fill < 3'd2);
   end

   // Two-entry skid buffer; buf0 is always the head.
   always_comb begin
      buf0_d = buf0_q;
      buf1_d = buf1_q;
      occ_d  = occ_q;
      if (pop) begin
         buf0_d = buf1_q;
         occ_d  = occ_q - 2'd1;
      end
      // A byte in flight is always captured; the throttle guarantees a free slot.
      if (inflight_q) begin
         if (occ_d == 2'd0) begin
            buf0_d = fifo_rdata;
         end else begin
            buf1_d = fifo_rdata;
         end
         occ_d = occ_d + 2'd1;
      end
   end

   // Line sequencing FSM.
   always_comb begin
      state_d   = state_q;
      rd_cnt_d  = rd_cnt_q;
      out_cnt_d = out_cnt_q;
      gap_d     = gap_q;
      pend_d    = pend_q | frame_rst;
      line_d    = line_q;
      busy_d    = busy_q;

      if (fifo_ren) begin
         rd_cnt_d = rd_cnt_q - ONE_CNT;
      end
      if (pop) begin
         out_cnt_d = out_cnt_q - ONE_CNT;
      end

      unique case (state_q)
         StIdle: begin
            if (rdy_s_q) begin
               state_d   = StRead;
               rd_cnt_d  = FULL_CNT;
               out_cnt_d = FULL_CNT;
               busy_d    = 1'b1;
               if (pend_d) begin
                  line_d = '0;
                  pend_d = 1'b0;
               end
            end
         end
         StRead: begin
            if (fifo_ren && (rd_cnt_q == ONE_CNT)) begin
               state_d = StFlush;
            end
         end
         StFlush: begin
            if (last_pop) begin
               state_d = StGap;
               gap_d   = '0;
               busy_d  = 1'b0;
               if (frame_rst || (line_q == LAST_LINE)) begin
                  line_d = '0;
               end else begin
                  line_d = line_q + LINE_W'(1);
               end
            end
         end
         StGap: begin
            // Lets the write-side flag settle before it is looked at again.
            if (gap_q == GAP_LAST) begin
               state_d = StIdle;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= StIdle;
         rdy_m_q    <= 1'b0;
         rdy_s_q    <= 1'b0;
         rd_cnt_q   <= '0;
         out_cnt_q  <= '0;
         gap_q      <= '0;
         occ_q      <= 2'd0;
         buf0_q     <= 8'h00;
         buf1_q     <= 8'h00;
         inflight_q <= 1'b0;
         pend_q     <= 1'b0;
         line_q     <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rdy_m_q    <= line_rdy;
         rdy_s_q    <= rdy_m_q;
         rd_cnt_q   <= rd_cnt_d;
         out_cnt_q  <= out_cnt_d;
         gap_q      <= gap_d;
         occ_q      <= occ_d;
         buf0_q     <= buf0_d;
         buf1_q     <= buf1_d;
         inflight_q <= fifo_ren;
         pend_q     <= pend_d;
         line_q     <= line_d;
         busy_q     <= busy_d;
      end
   end

endmodule

// File: tb/tb_line_drain.sv
module tb_line_drain;
   localparam int unsigned LB  = 48;
   localparam int unsigned NL  = 9;
   localparam int unsigned LW  = 4;
   localparam int unsigned GAP = 8;

   logic          clk       = 1'b0;
   logic          rstn      = 1'b0;
   logic          line_rdy  = 1'b0;
   logic          frame_rst = 1'b0;
   logic          m_ready   = 1'b0;
   logic          fifo_ren;
   logic [7:0]    fifo_rdata = 8'h00;
   logic [7:0]    m_data;
   logic          m_valid;
   logic          m_sol;
   logic          m_eol;
   logic          busy;
   logic [LW-1:0] m_line;

   line_drain #(
      .LINE_BYTES(LB),
      .LINES     (NL),
      .LINE_W    (LW),
      .GAP_CYC   (GAP)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .line_rdy  (line_rdy),
      .frame_rst (frame_rst),
      .fifo_ren  (fifo_ren),
      .fifo_rdata(fifo_rdata),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_sol     (m_sol),
      .m_eol     (m_eol),
      .m_line    (m_line),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // FIFO model: random byte per read, returned one cycle later; queue holds bytes read
   // but not yet accepted downstream, in FIFO order.
   logic [7:0] exp_q[$];
   logic [7:0] nb;
   int         issued = 0;

   always @(posedge clk) begin
      if (fifo_ren) begin
         nb = 8'($urandom);
         fifo_rdata <= nb;
         exp_q.push_back(nb);
         issued++;
      end
   end

   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   acc = 0;
   int   exp_line = 0;
   bit   zero_next = 1'b0;
   int   lines_rst = 0;
   int   lines_done = 0;
   int   since_eol = -1;
   bit   gap_en = 1'b1;
   bit   contig_en = 1'b0;
   int   sol_cyc = 0;
   bit   busy_chk_next = 1'b0;
   bit   hold_pend = 1'b0;
   logic [7:0] h_data;
   logic h_sol;
   logic h_eol;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs on the falling edge, sample shortly after.
   task automatic tick(input logic rdy, input logic lrdy, input logic frst, input logic rn);
      logic       was_rst;
      logic [7:0] b;
      @(negedge clk);
      was_rst   = !rstn;
      m_ready   = rdy;
      line_rdy  = lrdy;
      frame_rst = frst;
      rstn      = rn;
      #1;
      cyc++;
      if (was_rst) begin
         chk("rst_ren", fifo_ren, 0);
         chk("rst_valid", m_valid, 0);
         chk("rst_sol", m_sol, 0);
         chk("rst_eol", m_eol, 0);
         chk("rst_data", m_data, 0);
         chk("rst_line", m_line, 0);
         chk("rst_busy", busy, 0);
         exp_q.delete();
         issued        = 0;
         acc           = 0;
         exp_line      = 0;
         zero_next     = 1'b0;
         lines_rst     = 0;
         since_eol     = -1;
         hold_pend     = 1'b0;
         busy_chk_next = 1'b0;
      end
      if (!rn) begin
         hold_pend = 1'b0;
         return;
      end
      if (busy_chk_next) begin
         chk("busy_fall", busy, 0);
         busy_chk_next = 1'b0;
      end
      if (hold_pend) begin
         chk("hold_valid", m_valid, 1);
         chk("hold_data", m_data, h_data);
         chk("hold_sol", m_sol, h_sol);
         chk("hold_eol", m_eol, h_eol);
      end
      chk("outstanding_le3", exp_q.size() <= 3, 1);
      if (since_eol >= 0) since_eol++;
      if (fifo_ren && since_eol > 0) begin
         if (gap_en) chk("gap_len", since_eol, GAP + 2);
         since_eol = -1;
      end
      if (m_valid && m_ready) begin
         chk("accept_nonempty", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            b = exp_q.pop_front();
            if (acc == 0 && zero_next) begin
               exp_line  = 0;
               zero_next = 1'b0;
            end
            chk("data", m_data, b);
            chk("sol", m_sol, acc == 0);
            chk("eol", m_eol, acc == LB - 1);
            chk("line", m_line, exp_line);
            chk("busy", busy, 1);
            if (acc == 0) sol_cyc = cyc;
            acc++;
            if (acc == LB) begin
               chk("ren_count", issued, (lines_rst + 1) * LB);
               if (contig_en) chk("contig", cyc - sol_cyc, LB - 1);
               acc           = 0;
               lines_rst++;
               lines_done++;
               exp_line      = (exp_line + 1) % NL;
               since_eol     = 0;
               busy_chk_next = 1'b1;
            end
         end
      end
      hold_pend = m_valid && !m_ready;
      h_data    = m_data;
      h_sol     = m_sol;
      h_eol     = m_eol;
   endtask

   // mode 0: ready held, 1: ready toggling, 2: ready random (75%).
   task automatic run_line(input int mode, input int stall_at, input int frst_at, input bit lrand);
      int   target;
      int   budget;
      bit   done_stall;
      bit   done_frst;
      int   ren_in_stall;
      logic rdy;
      logic lrdy;
      target     = lines_done + 1;
      budget     = 20 * LB + 400;
      done_stall = 1'b0;
      done_frst  = 1'b0;
      contig_en  = (mode == 0) && (stall_at < 0);
      gap_en     = !lrand;
      if (lrand) since_eol = -1;
      while (lines_done < target && budget > 0) begin
         budget--;
         if (stall_at >= 0 && !done_stall && acc == stall_at) begin
            done_stall   = 1'b1;
            ren_in_stall = 0;
            for (int i = 0; i < 100; i++) begin
               tick(1'b0, 1'b1, 1'b0, 1'b1);
               if (i >= 2 && fifo_ren) ren_in_stall++;
            end
            chk("stall_ren", ren_in_stall, 0);
         end else if (frst_at >= 0 && !done_frst && acc == frst_at) begin
            done_frst = 1'b1;
            zero_next = 1'b1;
            tick(1'b1, 1'b1, 1'b1, 1'b1);
         end else begin
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = ((cyc % 2) == 0);
            else rdy = ($urandom_range(0, 3) != 0);
            lrdy = lrand ? 1'($urandom_range(0, 1)) : 1'b1;
            tick(rdy, lrdy, 1'b0, 1'b1);
         end
      end
      chk("line_done", lines_done, target);
   endtask

   initial begin
      int n;
      int bud;
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b0, 1'b1);
      n = 0;
      while (!fifo_ren && n < 10) begin
         tick(1'b1, 1'b1, 1'b0, 1'b1);
         n++;
      end
      chk("first_ren_lat", n, 3);

      run_line(0, -1, -1, 1'b0);        // line 0, full rate
      run_line(1, -1, -1, 1'b0);        // line 1, ready 1010...
      run_line(0, LB / 2, -1, 1'b0);    // line 2, 100-cycle stall mid-line
      for (int i = 0; i < 10; i++) run_line(2, -1, -1, 1'b0);  // wraps past NL-1
      run_line(2, -1, -1, 1'b0);        // line 4
      run_line(2, -1, LB / 3, 1'b0);    // line 5 with frame_rst
      run_line(2, -1, -1, 1'b0);        // reports 0
      run_line(2, -1, -1, 1'b1);        // line_rdy toggling during the line

      for (int i = 0; i < 50; i++) tick(1'b1, 1'b0, 1'b0, 1'b1);
      chk("idle_ren_count", issued, lines_rst * LB);
      chk("idle_no_bytes", exp_q.size(), 0);
      since_eol = -1;

      // Reset in the middle of a line.
      gap_en    = 1'b1;
      contig_en = 1'b0;
      bud       = 40 * LB;
      while (acc != LB / 2 && bud > 0) begin
         tick(1'b1, 1'b1, 1'b0, 1'b1);
         bud--;
      end
      chk("reach_mid", acc, LB / 2);
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b0, 1'b1);
      run_line(0, -1, -1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
